// File: rtl/axil_regif.sv
// AXI4-Lite slave register file: pNUM_REGS read/write registers plus a read-only status word at byte 0x100.
// Optional feature macro AXIL_REGIF_WSTRB_EN: honour wstrb byte enables; without it every write replaces the full word.

module axil_regif #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pNUM_REGS   = 8
) (
    input  logic                     axi_clk,
    input  logic                     axi_reset_n,
    input  logic                     awvalid,
    input  logic [pADDR_WIDTH-1:0]   awaddr,
    output logic                     awready,
    input  logic                     wvalid,
    input  logic [pDATA_WIDTH-1:0]   wdata,
    input  logic [3:0]               wstrb,
    output logic                     wready,
    input  logic                     arvalid,
    input  logic [pADDR_WIDTH-1:0]   araddr,
    output logic                     arready,
    output logic                     rvalid,
    output logic [pDATA_WIDTH-1:0]   rdata,
    input  logic                     rready,
    output logic [pNUM_REGS*32-1:0]  reg_out,
    output logic [pNUM_REGS-1:0]     reg_wr_pulse,
    input  logic [31:0]              sts_in
);

    localparam logic [9:0] STS_IDX = 10'h040;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_COMMIT} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic [9:0]  w_idx;
    logic [31:0] w_data;
    logic [31:0] regs [pNUM_REGS];
    logic [31:0] rd_value;
    logic        aw_hs, w_hs, ar_hs, r_hs;
    logic        unused_bits;
`ifdef AXIL_REGIF_WSTRB_EN
    logic [3:0]  w_strb;
`endif

    assign unused_bits = ^{awaddr, araddr, wstrb};

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Readies are gated by the reset input so they stay low while reset is held.
    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        if (axi_reset_n) begin
            case (w_state)
                W_IDLE: begin
                    awready = 1'b1;
                    wready  = 1'b1;
                    if (awvalid && wvalid) w_next = W_COMMIT;
                    else if (awvalid)      w_next = W_HAVE_A;
                    else if (wvalid)       w_next = W_HAVE_D;
                end
                W_HAVE_A: begin
                    wready = 1'b1;
                    if (wvalid) w_next = W_COMMIT;
                end
                W_HAVE_D: begin
                    awready = 1'b1;
                    if (awvalid) w_next = W_COMMIT;
                end
                default: w_next = W_IDLE;
            endcase
        end
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = axi_reset_n;
                if (arvalid && axi_reset_n) r_next = R_DATA;
            end
            default: begin
                rvalid = 1'b1;
                if (rready) r_next = R_IDLE;
            end
        endcase
    end

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            w_idx  <= '0;
            w_data <= '0;
`ifdef AXIL_REGIF_WSTRB_EN
            w_strb <= '0;
`endif
        end else begin
            if (aw_hs) w_idx <= awaddr[11:2];
            if (w_hs) begin
                w_data <= wdata;
`ifdef AXIL_REGIF_WSTRB_EN
                w_strb <= wstrb;
`endif
            end
        end
    end

    // Unmapped indices match no register, so the write is dropped and no pulse fires.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            for (int i = 0; i < pNUM_REGS; i++) regs[i] <= '0;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (w_state == W_COMMIT) begin
                for (int i = 0; i < pNUM_REGS; i++) begin
                    if (w_idx == 10'(i)) begin
`ifdef AXIL_REGIF_WSTRB_EN
                        for (int b = 0; b < 4; b++)
                            if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
`else
                        regs[i] <= w_data;
`endif
                        reg_wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_value = '0;
        if (araddr[11:2] == STS_IDX) rd_value = sts_in;
        for (int i = 0; i < pNUM_REGS; i++)
            if (araddr[11:2] == 10'(i)) rd_value = regs[i];
    end

    // Captured from pre-edge register values, so a same-edge write is not visible here.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n)  rdata <= '0;
        else if (ar_hs)    rdata <= rd_value;
        else if (r_hs)     rdata <= '0;
    end

    for (genvar g = 0; g < pNUM_REGS; g++) begin : g_reg_out
        assign reg_out[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_axil_regif.sv
// Scoreboard bench for axil_regif: directed AXI-Lite transactions push expected responses,
// a negedge monitor pops and compares whenever a read completes or a write pulse appears.

module tb_axil_regif;

    localparam int NUM_REGS = 8;

    logic                    axi_clk = 1'b0;
    logic                    axi_reset_n;
    logic                    awvalid, wvalid, arvalid, rready;
    logic [11:0]             awaddr, araddr;
    logic [31:0]             wdata, sts_in;
    logic [3:0]              wstrb;
    logic                    awready, wready, arready, rvalid;
    logic [31:0]             rdata;
    logic [NUM_REGS*32-1:0]  reg_out;
    logic [NUM_REGS-1:0]     reg_wr_pulse;

    typedef struct {
        int          idx;
        logic [31:0] value;
        logic [7:0]  pulse;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] model_regs [NUM_REGS];
    logic [31:0] mon_rd;
    wr_exp_t     mon_wr;
    logic        aw_done, w_done;
    int          n_checks = 0;
    int          n_fail = 0;

`ifdef AXIL_REGIF_WSTRB_EN
    localparam logic [31:0] REG0_AFTER_STRB  = 32'hFF00_FF00;
    localparam logic [31:0] REG0_AFTER_ZERO  = 32'hFF00_FF00;
`else
    localparam logic [31:0] REG0_AFTER_STRB  = 32'h0000_0000;
    localparam logic [31:0] REG0_AFTER_ZERO  = 32'h1234_5678;
`endif

    always #5 axi_clk = ~axi_clk;

    axil_regif #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pNUM_REGS(NUM_REGS)) dut (
        .axi_clk      (axi_clk),
        .axi_reset_n  (axi_reset_n),
        .awvalid      (awvalid),
        .awaddr       (awaddr),
        .awready      (awready),
        .wvalid       (wvalid),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wready       (wready),
        .arvalid      (arvalid),
        .araddr       (araddr),
        .arready      (arready),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .rready       (rready),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse),
        .sts_in       (sts_in)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'b0, actual}, {31'b0, expected});
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s timed out waiting for handshake", name);
    endtask

    task automatic sync_edge();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic check_all_regs_zero(input string name);
        for (int i = 0; i < NUM_REGS; i++) checkOutput(name, reg_out[32*i +: 32], 32'h0);
    endtask

    // Write transaction; channel delays are counted in cycles from the call.
    task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                 input int aw_delay, input int w_delay);
        logic [9:0]  idx;
        logic [31:0] next_val;
        wr_exp_t     e;
        logic        aw_got, w_got;
        idx = addr[11:2];
        if (idx < NUM_REGS) begin
            next_val = model_regs[idx];
`ifdef AXIL_REGIF_WSTRB_EN
            for (int b = 0; b < 4; b++) if (strb[b]) next_val[8*b +: 8] = data[8*b +: 8];
`else
            next_val = data;
`endif
            model_regs[idx] = next_val;
            e.idx   = int'(idx);
            e.value = next_val;
            e.pulse = '0;
            e.pulse[idx[2:0]] = 1'b1;
            wr_q.push_back(e);
        end
        aw_done = 1'b0;
        w_done  = 1'b0;
        fork
            begin
                for (int k = 0; k < aw_delay; k++) begin
                    @(negedge axi_clk);
                    if (w_done) checkBit("wready_low_until_aw", wready, 1'b0);
                    sync_edge();
                end
                awvalid = 1'b1;
                awaddr  = addr;
                aw_got  = 1'b0;
                for (int k = 0; k < 20 && !aw_got; k++) begin
                    @(negedge axi_clk);
                    if (w_done) checkBit("wready_low_until_aw", wready, 1'b0);
                    if (awready) aw_got = 1'b1;
                end
                if (!aw_got) report_timeout("aw_handshake");
                sync_edge();
                awvalid = 1'b0;
                aw_done = 1'b1;
            end
            begin
                for (int k = 0; k < w_delay; k++) begin
                    @(negedge axi_clk);
                    if (aw_done) checkBit("awready_low_until_w", awready, 1'b0);
                    sync_edge();
                end
                wvalid = 1'b1;
                wdata  = data;
                wstrb  = strb;
                w_got  = 1'b0;
                for (int k = 0; k < 20 && !w_got; k++) begin
                    @(negedge axi_clk);
                    if (aw_done) checkBit("awready_low_until_w", awready, 1'b0);
                    if (wready) w_got = 1'b1;
                end
                if (!w_got) report_timeout("w_handshake");
                sync_edge();
                wvalid = 1'b0;
                w_done = 1'b1;
            end
        join
    endtask

    task automatic read_txn(input logic [11:0] addr, input int stall, input logic [31:0] expected);
        logic got;
        rd_q.push_back(expected);
        arvalid = 1'b1;
        araddr  = addr;
        got     = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge axi_clk);
            if (arready) got = 1'b1;
        end
        if (!got) report_timeout("ar_handshake");
        sync_edge();
        arvalid = 1'b0;
        @(negedge axi_clk);
        checkBit("rvalid_after_ar", rvalid, 1'b1);
        checkBit("arready_low_in_rdata", arready, 1'b0);
        for (int k = 0; k < stall; k++) begin
            sync_edge();
            @(negedge axi_clk);
            checkBit("rvalid_stall", rvalid, 1'b1);
            checkOutput("rdata_stall", rdata, expected);
            checkBit("arready_stall", arready, 1'b0);
        end
        sync_edge();
        rready = 1'b1;
        @(negedge axi_clk);
        sync_edge();
        rready = 1'b0;
        @(negedge axi_clk);
        checkBit("rvalid_after_r", rvalid, 1'b0);
        checkOutput("rdata_zero_idle", rdata, 32'h0);
        checkBit("arready_after_r", arready, 1'b1);
    endtask

    // Monitor: pops an expectation whenever the DUT completes a read or pulses a register write.
    always @(negedge axi_clk) begin
        if (axi_reset_n) begin
            if (rvalid && rready) begin
                if (rd_q.size() == 0) begin
                    report_timeout("unexpected_read_response");
                end else begin
                    mon_rd = rd_q.pop_front();
                    checkOutput("rdata", rdata, mon_rd);
                end
            end
            if (reg_wr_pulse != '0) begin
                if (wr_q.size() == 0) begin
                    checkOutput("unexpected_wr_pulse", {24'b0, reg_wr_pulse}, 32'h0);
                end else begin
                    mon_wr = wr_q.pop_front();
                    checkOutput("wr_pulse", {24'b0, reg_wr_pulse}, {24'b0, mon_wr.pulse});
                    checkOutput("wr_value", reg_out[mon_wr.idx*32 +: 32], mon_wr.value);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        axi_reset_n = 1'b0;
        awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0;
        arvalid = 1'b0; araddr = '0; rready = 1'b0; sts_in = '0;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;

        repeat (3) @(posedge axi_clk);
        @(negedge axi_clk);
        checkBit("rst_awready", awready, 1'b0);
        checkBit("rst_wready", wready, 1'b0);
        checkBit("rst_arready", arready, 1'b0);
        checkBit("rst_rvalid", rvalid, 1'b0);
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_pulse", {24'b0, reg_wr_pulse}, 32'h0);
        check_all_regs_zero("rst_reg");
        sync_edge();
        axi_reset_n = 1'b1;
        @(negedge axi_clk);
        checkBit("rel_awready", awready, 1'b1);
        checkBit("rel_wready", wready, 1'b1);
        checkBit("rel_arready", arready, 1'b1);
        sync_edge();

        $display("[TB] simultaneous AW/W write to reg1");
        applyStimulus(12'h004, 32'hA5A5_0001, 4'hF, 0, 0);
        @(negedge axi_clk);
        checkBit("commit_awready", awready, 1'b0);
        checkBit("commit_wready", wready, 1'b0);
        checkOutput("commit_no_pulse", {24'b0, reg_wr_pulse}, 32'h0);
        @(negedge axi_clk);
        checkOutput("pulse_two_cycles", {24'b0, reg_wr_pulse}, 32'h0000_0002);
        checkOutput("reg1_value", reg_out[63:32], 32'hA5A5_0001);
        @(negedge axi_clk);
        checkOutput("pulse_one_cycle", {24'b0, reg_wr_pulse}, 32'h0);
        sync_edge();

        $display("[TB] W leads AW by three cycles");
        applyStimulus(12'h008, 32'h1234_5678, 4'hF, 3, 0);
        repeat (3) sync_edge();
        checkOutput("reg2_value", reg_out[95:64], 32'h1234_5678);

        $display("[TB] status read with stalled rready");
        sts_in = 32'hCAFE_F00D;
        read_txn(12'h100, 4, 32'hCAFE_F00D);
        sync_edge();
        read_txn(12'h007, 0, 32'hA5A5_0001);
        sync_edge();
        read_txn(12'h009, 0, 32'h1234_5678);
        sync_edge();

        $display("[TB] unmapped addresses");
        read_txn(12'h3FC, 0, 32'h0);
        sync_edge();
        read_txn(12'h020, 0, 32'h0);
        sync_edge();
        applyStimulus(12'h040, 32'hDEAD_BEEF, 4'hF, 0, 0);
        repeat (3) begin
            @(negedge axi_clk);
            checkOutput("no_pulse_unmapped", {24'b0, reg_wr_pulse}, 32'h0);
        end
        checkOutput("reg0_untouched", reg_out[31:0], 32'h0);
        sync_edge();
        applyStimulus(12'h100, 32'h0BAD_0BAD, 4'hF, 0, 0);
        repeat (3) begin
            @(negedge axi_clk);
            checkOutput("no_pulse_status", {24'b0, reg_wr_pulse}, 32'h0);
        end
        sync_edge();
        applyStimulus(12'h01C, 32'h7777_0007, 4'hF, 0, 1);
        repeat (3) sync_edge();
        read_txn(12'h01C, 0, 32'h7777_0007);
        sync_edge();

        $display("[TB] byte strobes on reg0");
        applyStimulus(12'h000, 32'hFFFF_FFFF, 4'hF, 0, 0);
        repeat (3) sync_edge();
        applyStimulus(12'h000, 32'h0000_0000, 4'b0101, 1, 0);
        repeat (3) sync_edge();
        read_txn(12'h000, 0, REG0_AFTER_STRB);
        sync_edge();
        applyStimulus(12'h000, 32'h1234_5678, 4'b0000, 0, 2);
        repeat (3) sync_edge();
        read_txn(12'h000, 0, REG0_AFTER_ZERO);
        sync_edge();

        $display("[TB] read captured on the same edge as a write");
        fork
            applyStimulus(12'h00C, 32'h0BAD_F00D, 4'hF, 0, 0);
            begin
                sync_edge();
                read_txn(12'h00C, 0, 32'h0);
            end
        join
        repeat (3) sync_edge();
        read_txn(12'h00C, 0, 32'h0BAD_F00D);
        sync_edge();

        $display("[TB] reset during W_HAVE_A and R_DATA");
        awvalid = 1'b1; awaddr = 12'h014;
        arvalid = 1'b1; araddr = 12'h004;
        @(negedge axi_clk);
        checkBit("pre_rst_awready", awready, 1'b1);
        checkBit("pre_rst_arready", arready, 1'b1);
        sync_edge();
        awvalid = 1'b0;
        arvalid = 1'b0;
        @(negedge axi_clk);
        checkBit("pre_rst_rvalid", rvalid, 1'b1);
        checkOutput("pre_rst_rdata", rdata, 32'hA5A5_0001);
        checkBit("pre_rst_awready_low", awready, 1'b0);
        checkBit("pre_rst_wready", wready, 1'b1);
        #1;
        axi_reset_n = 1'b0;
        #1;
        checkBit("mid_rst_rvalid", rvalid, 1'b0);
        checkOutput("mid_rst_rdata", rdata, 32'h0);
        checkBit("mid_rst_awready", awready, 1'b0);
        checkBit("mid_rst_wready", wready, 1'b0);
        checkBit("mid_rst_arready", arready, 1'b0);
        checkOutput("mid_rst_pulse", {24'b0, reg_wr_pulse}, 32'h0);
        check_all_regs_zero("mid_rst_reg");
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
        sync_edge();
        axi_reset_n = 1'b1;
        @(negedge axi_clk);
        checkBit("post_rst_awready", awready, 1'b1);
        checkBit("post_rst_wready", wready, 1'b1);
        checkBit("post_rst_arready", arready, 1'b1);
        checkBit("post_rst_rvalid", rvalid, 1'b0);
        repeat (3) begin
            @(negedge axi_clk);
            checkOutput("post_rst_no_pulse", {24'b0, reg_wr_pulse}, 32'h0);
        end
        sync_edge();
        applyStimulus(12'h014, 32'h55AA_55AA, 4'hF, 0, 0);
        repeat (3) sync_edge();
        read_txn(12'h004, 0, 32'h0);
        sync_edge();
        read_txn(12'h014, 0, 32'h55AA_55AA);
        repeat (2) sync_edge();

        checkOutput("wr_queue_drained", wr_q.size(), 32'h0);
        checkOutput("rd_queue_drained", rd_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_regif.md
AXIL_REGIF -- requirements
Module: axil_regif

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 12, AXI-Lite address width.
REQ-002 SHALL have parameter pDATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter pNUM_REGS, default 8, number of read/write registers (1..64).
REQ-004 SHALL have port axi_clk, input, 1, sole clock; all logic is rising-edge.
REQ-005 SHALL have port axi_reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports awvalid in 1, awaddr in pADDR_WIDTH, awready out 1: write-address channel.
REQ-007 SHALL have ports wvalid in 1, wdata in pDATA_WIDTH, wstrb in 4, wready out 1: write-data channel.
REQ-008 SHALL have ports arvalid in 1, araddr in pADDR_WIDTH, arready out 1: read-address channel.
REQ-009 SHALL have ports rvalid out 1, rdata out pDATA_WIDTH, rready in 1: read-data channel.
REQ-010 SHALL have port reg_out, output, pNUM_REGS*32, flat register contents; reg i occupies bits [32i+31:32i].
REQ-011 SHALL have port reg_wr_pulse, output, pNUM_REGS, one-cycle per-register write strobe.
REQ-012 SHALL have port sts_in, input, 32, read-only hardware status word.

Function
REQ-013 SHALL decode word index = addr[11:2]; addr[1:0] are ignored.
REQ-014 SHALL map index 0..pNUM_REGS-1 to registers and byte address 0x100 to sts_in; all other addresses read 0, and writes to them are discarded with no pulse.
REQ-015 SHALL run the write FSM through W_IDLE, W_HAVE_A, W_HAVE_D and W_COMMIT.
REQ-016 Write-FSM outputs: awready=1 in W_IDLE/W_HAVE_D; wready=1 in W_IDLE/W_HAVE_A; both 0 in W_COMMIT.
REQ-017 Write-FSM transitions: W_IDLE goes to W_COMMIT on simultaneous AW and W handshakes, to W_HAVE_A on AW only, and to W_HAVE_D on W only; W_HAVE_A/W_HAVE_D go to W_COMMIT on the missing handshake; W_COMMIT always goes to W_IDLE.
REQ-018 SHALL latch the address and data/strobe at their respective handshakes.
REQ-019 SHALL update the target register at the edge ending W_COMMIT; the new value and reg_wr_pulse[i]=1 appear together in the following cycle, for exactly one cycle.
REQ-020 SHALL run the read FSM through R_IDLE (arready=1, rvalid=0) and R_DATA (arready=0, rvalid=1).
REQ-021 On an AR handshake the read FSM SHALL capture rdata from register/sts_in values as of that cycle and assert rvalid on the next cycle.
REQ-022 SHALL hold rdata and rvalid stable until rready; on the R handshake it SHALL return to R_IDLE, with arready high the next cycle (max one read per 2 cycles).
REQ-023 SHALL run the read and write FSMs independently.
REQ-024 A read captured in the same cycle the target register updates SHALL return the pre-update value.
REQ-025 SHALL hold rdata at 0 whenever rvalid=0.

Reset
REQ-026 While axi_reset_n=0, SHALL force all registers to 0, reg_wr_pulse=0, rvalid=0, rdata=0, awready=wready=arready=0, and FSMs to W_IDLE/R_IDLE.
REQ-027 SHALL raise awready, wready and arready in the first cycle after axi_reset_n deasserts.
REQ-028 Reset mid-transaction SHALL drop pending latched address/data without a register update; rvalid falls asynchronously.

Configuration
REQ-029 Macro AXIL_REGIF_WSTRB_EN defined: SHALL update only the bytes whose wstrb bit is 1; wstrb=0000 still pulses reg_wr_pulse with the value unchanged.
REQ-030 Macro AXIL_REGIF_WSTRB_EN undefined: SHALL ignore wstrb and write the full 32-bit word.

Verification
REQ-031 Reset release, then AW(0x004) and W(0xA5A5_0001, wstrb 1111) in the same cycle -> reg_out[63:32]=0xA5A5_0001 and reg_wr_pulse=0000_0010 for one cycle, 2 cycles after the handshake.
REQ-032 W(0x1234_5678) 3 cycles before AW(0x008) -> wready low after the W handshake until commit; reg 2=0x1234_5678.
REQ-033 sts_in=0xCAFE_F00D, AR(0x100), rready held low 4 cycles -> rvalid high with rdata=0xCAFE_F00D, stable through stall; arready low until 1 cycle after the R handshake.
REQ-034 AR(0x3FC) and AW/W(0x040) -> rdata=0 and no reg_wr_pulse bit set.
REQ-035 With AXIL_REGIF_WSTRB_EN: reg0=0xFFFF_FFFF, write 0x0000_0000 with wstrb 0101 -> reg0=0xFF00_FF00; without the macro -> reg0=0x0000_0000.
REQ-036 axi_reset_n pulsed low while in W_HAVE_A and R_DATA -> rvalid=0 immediately, all registers 0, FSMs idle, no pulse emitted.
